// File: rtl/o_feature_drain.sv
// o_feature_drain: drains finished output features from Tm channel FIFOs in
// feature-major, channel-minor order. Each feature can optionally be clamped
// by ReLU. Features are presented one per transfer on a valid/ready stream.
module o_feature_drain #(
    parameter int unsigned Tm            = 4,
    parameter int unsigned FEATURE_WIDTH = 16,
    parameter int unsigned CNT_WIDTH     = 16,
    localparam int unsigned CH_W         = (Tm > 1) ? $clog2(Tm) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_WIDTH-1:0]        feature_count,
    input  logic                        relu_en,
    input  logic [Tm-1:0]               fifo_empty,
    output logic [Tm-1:0]               fifo_rd_en,
    input  logic [Tm*FEATURE_WIDTH-1:0] fifo_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [FEATURE_WIDTH-1:0]    out_data,
    output logic [CH_W-1:0]             out_ch,
    output logic [CNT_WIDTH-1:0]        out_idx,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_CAPT,
        S_SEND,
        S_DONE
    } state_e;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(Tm - 1);

    state_e                   state_q;
    logic [CH_W-1:0]          ch_q;
    logic [CNT_WIDTH-1:0]     k_q;
    logic [CNT_WIDTH-1:0]     cnt_q;
    logic                     relu_q;
    logic                     out_valid_q;
    logic [FEATURE_WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]          out_ch_q;
    logic [CNT_WIDTH-1:0]     out_idx_q;

    logic                     sel_empty;
    logic [FEATURE_WIDTH-1:0] sel_data;
    logic                     last_ch;
    logic                     last_k;

    // Select the current channel's empty flag and read data.
    always_comb begin
        sel_empty = 1'b1;
        sel_data  = '0;
        for (int unsigned c = 0; c < Tm; c++) begin
            if (ch_q == CH_W'(c)) begin
                sel_empty = fifo_empty[c];
                sel_data  = fifo_data[c*FEATURE_WIDTH +: FEATURE_WIDTH];
            end
        end
    end

    // The read strobe is decoded from the registered state and channel.
    // A read is issued only when the selected FIFO has data.
    always_comb begin
        fifo_rd_en = '0;
        for (int unsigned c = 0; c < Tm; c++) begin
            fifo_rd_en[c] = (state_q == S_REQ) && (ch_q == CH_W'(c)) && !fifo_empty[c];
        end
    end

    assign last_ch = (ch_q == LAST_CH);
    assign last_k  = (k_q == cnt_q - CNT_WIDTH'(1));

    // Drain sequencer: state, position counters and registered stream outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_idx_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cnt_q   <= feature_count;
                        relu_q  <= relu_en;
                        ch_q    <= '0;
                        k_q     <= '0;
                        state_q <= (feature_count == '0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (!sel_empty) begin
                        state_q <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    out_data_q  <= (relu_q && sel_data[FEATURE_WIDTH-1]) ? '0 : sel_data;
                    out_ch_q    <= ch_q;
                    out_idx_q   <= k_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_ch) begin
                            ch_q    <= '0;
                            k_q     <= k_q + CNT_WIDTH'(1);
                            state_q <= last_k ? S_DONE : S_REQ;
                        end else begin
                            ch_q    <= ch_q + CH_W'(1);
                            state_q <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_idx   = out_idx_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_o_feature_drain.sv
// Self-checking bench for o_feature_drain: models the channel FIFOs and
// checks every transfer against an order/ReLU reference built from the
// loaded FIFO contents.
module tb_o_feature_drain;

    localparam int unsigned TM  = 4;
    localparam int unsigned FW  = 16;
    localparam int unsigned CW  = 16;
    localparam int unsigned CHW = 2;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned NOBS  = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [CW-1:0]     feature_count = '0;
    logic              relu_en = 1'b0;
    logic [TM-1:0]     fifo_empty;
    logic [TM-1:0]     fifo_rd_en;
    logic [TM*FW-1:0]  fifo_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [FW-1:0]     out_data;
    logic [CHW-1:0]    out_ch;
    logic [CW-1:0]     out_idx;
    logic              busy;
    logic              done;

    o_feature_drain #(
        .Tm            (TM),
        .FEATURE_WIDTH (FW),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .feature_count (feature_count),
        .relu_en       (relu_en),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_data     (fifo_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ch        (out_ch),
        .out_idx       (out_idx),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- FIFO model ----------------
    logic [FW-1:0] mem [TM][DEPTH];
    int  rp [TM] = '{default: 0};
    int  wc [TM] = '{default: 0};
    bit  stall [TM] = '{default: 1'b0};

    always_comb begin
        for (int c = 0; c < TM; c++) begin
            fifo_empty[c] = (rp[c] >= wc[c]) || stall[c];
        end
    end

    always @(posedge clk) begin
        for (int c = 0; c < TM; c++) begin
            if (fifo_rd_en[c] === 1'b1) begin
                fifo_data[c*FW +: FW] <= mem[c][rp[c] % DEPTH];
                rp[c] <= rp[c] + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0;
    int cycE = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [FW-1:0] obs_data [NOBS];
    int obs_ch  [NOBS];
    int obs_idx [NOBS];
    int obs_rel [NOBS];
    int xfer_n = 0;
    int done_n = 0;
    int done_rel = -1;
    int onehot_v = 0, rdsend_v = 0, rdempty_v = 0, hold_v = 0;
    bit hold_pend = 1'b0;
    logic [FW+CHW+CW:0] hold_snap = '0;

    always @(negedge clk) begin
        if (rst) begin
            if ($countones(fifo_rd_en) > 1) onehot_v++;
            if (fifo_rd_en != '0 && out_valid) rdsend_v++;
            if ((fifo_rd_en & fifo_empty) != '0) rdempty_v++;
            if (hold_pend && {out_valid, out_data, out_ch, out_idx} !== hold_snap) hold_v++;
            hold_pend = out_valid && !out_ready;
            hold_snap = {out_valid, out_data, out_ch, out_idx};
            if (done) begin
                done_n++;
                done_rel = cyc - cycE + 1;
            end
            if (out_valid && out_ready && xfer_n < NOBS) begin
                obs_data[xfer_n] = out_data;
                obs_ch[xfer_n]   = int'(out_ch);
                obs_idx[xfer_n]  = int'(out_idx);
                obs_rel[xfer_n]  = cyc - cycE + 1;
                xfer_n++;
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    // ---------------- reference expectations ----------------
    logic [FW-1:0] exp_data [NOBS];
    int exp_ch  [NOBS];
    int exp_idx [NOBS];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: random values, 1: 0x0100*(k+1)+c, 2: fixed ReLU corner values
    task automatic plan_drain(input int cnt, input bit relu, input int mode, output int base);
        logic [FW-1:0] v;
        logic [FW-1:0] relu_vals [TM];
        relu_vals = '{16'hFF38, 16'h00C8, 16'h8000, 16'h7FFF};
        base = xfer_n;
        for (int c = 0; c < TM; c++) begin
            wc[c] = rp[c];
            for (int k = 0; k < cnt; k++) begin
                case (mode)
                    1: v = FW'(16'h0100 * (k + 1) + c);
                    2: v = relu_vals[c];
                    default: v = FW'($urandom);
                endcase
                mem[c][(wc[c] + k) % DEPTH] = v;
            end
            wc[c] = wc[c] + cnt;
        end
        for (int k = 0; k < cnt; k++) begin
            for (int c = 0; c < TM; c++) begin
                v = mem[c][(rp[c] + k) % DEPTH];
                exp_data[base + k*TM + c] = (relu && v[FW-1]) ? '0 : v;
                exp_ch[base + k*TM + c]   = c;
                exp_idx[base + k*TM + c]  = k;
            end
        end
    endtask

    task automatic pulse_start(input int cnt, input bit relu);
        feature_count = CW'(cnt);
        relu_en = relu;
        start = 1'b1;
        tick();
        cycE = cyc;
        start = 1'b0;
        relu_en = 1'b0;
        feature_count = '0;
    endtask

    task automatic wait_done(input int d0, input int limit, input bit rnd);
        for (int i = 0; i < limit && done_n == d0; i++) begin
            if (rnd) begin
                out_ready = 1'($urandom_range(0, 1));
                for (int c = 0; c < TM; c++) stall[c] = ($urandom_range(0, 3) == 0);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < TM; c++) stall[c] = 1'b0;
        check("drain_done_pulses", done_n - d0, 1);
    endtask

    task automatic verify(input int base, input int n);
        check("xfer_count", xfer_n - base, n);
        for (int i = 0; i < n && base + i < xfer_n; i++) begin
            check($sformatf("data[%0d]", i), obs_data[base+i], exp_data[base+i]);
            check($sformatf("ch[%0d]", i),   obs_ch[base+i],   exp_ch[base+i]);
            check($sformatf("idx[%0d]", i),  obs_idx[base+i],  exp_idx[base+i]);
        end
    endtask

    initial begin
        int base, d0, bad, cnt;
        bit relu;

        // reset state
        tick(); tick();
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ch", out_ch, 0);
        check("rst_idx", out_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        tick();

        // basic drain with exact timing
        plan_drain(2, 1'b0, 1, base);
        d0 = done_n;
        pulse_start(2, 1'b0);
        wait_done(d0, 100, 1'b0);
        verify(base, 8);
        for (int i = 0; i < 8; i++) check($sformatf("basic_rel[%0d]", i), obs_rel[base+i], 3 + 3*i);
        check("basic_done_cycle", done_rel, 25);
        check("basic_data0", obs_data[base], 16'h0100);
        check("basic_data7", obs_data[base+7], 16'h0203);
        tick();

        // backpressure on (k0,ch1)
        plan_drain(2, 1'b0, 1, base);
        d0 = done_n;
        pulse_start(2, 1'b0);
        for (int i = 0; i < 50 && !(out_valid === 1'b1 && out_ch == 2'd1); i++) tick();
        out_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (out_data !== 16'h0101 || fifo_rd_en !== '0 || out_valid !== 1'b1) bad++;
            tick();
        end
        out_ready = 1'b1;
        check("bp_hold_bad_cycles", bad, 0);
        wait_done(d0, 100, 1'b0);
        verify(base, 8);
        tick();

        // empty stall on channel 2
        plan_drain(1, 1'b0, 1, base);
        stall[2] = 1'b1;
        d0 = done_n;
        pulse_start(1, 1'b0);
        for (int i = 0; i < 50 && xfer_n < base + 2; i++) tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (fifo_rd_en !== '0 || busy !== 1'b1 || out_valid !== 1'b0) bad++;
            tick();
        end
        check("stall_bad_cycles", bad, 0);
        stall[2] = 1'b0;
        #1;
        check("stall_release_rd", fifo_rd_en, 4'b0100);
        wait_done(d0, 100, 1'b0);
        verify(base, 4);
        tick();

        // ReLU enabled and disabled
        plan_drain(1, 1'b1, 2, base);
        d0 = done_n;
        pulse_start(1, 1'b1);
        wait_done(d0, 100, 1'b0);
        verify(base, 4);
        check("relu_neg", obs_data[base], 16'h0000);
        check("relu_pos", obs_data[base+1], 16'h00C8);
        tick();
        plan_drain(1, 1'b0, 2, base);
        d0 = done_n;
        pulse_start(1, 1'b0);
        wait_done(d0, 100, 1'b0);
        verify(base, 4);
        check("norelu_neg", obs_data[base], 16'hFF38);
        tick();

        // zero count
        base = xfer_n;
        d0 = done_n;
        pulse_start(0, 1'b0);
        bad = (fifo_rd_en !== '0 || out_valid !== 1'b0) ? 1 : 0;
        check("zero_done_next_cycle", done, 1);
        tick();
        check("zero_done_one_cycle", done, 0);
        check("zero_idle", busy, 0);
        check("zero_no_read_or_valid", bad, 0);
        check("zero_done_count", done_n - d0, 1);
        check("zero_xfers", xfer_n - base, 0);

        // start pulse while busy is ignored
        plan_drain(2, 1'b0, 0, base);
        d0 = done_n;
        pulse_start(2, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        feature_count = CW'(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        feature_count = '0;
        wait_done(d0, 200, 1'b0);
        verify(base, 8);
        tick();

        // randomized drains with random backpressure and empty flicker
        for (int it = 0; it < 8; it++) begin
            cnt = $urandom_range(1, 6);
            relu = 1'($urandom_range(0, 1));
            plan_drain(cnt, relu, 0, base);
            d0 = done_n;
            pulse_start(cnt, relu);
            wait_done(d0, 2000, 1'b1);
            verify(base, cnt * TM);
            tick();
        end

        // reset mid-run while out_valid is high
        plan_drain(3, 1'b0, 0, base);
        d0 = done_n;
        pulse_start(3, 1'b0);
        for (int i = 0; i < 50 && out_valid !== 1'b1; i++) tick();
        check("pre_reset_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_ch", out_ch, 0);
        check("midrst_idx", out_idx, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_rd_en", fifo_rd_en, 0);
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("post_rst_idle", busy, 0);
        check("post_rst_no_done", done_n - d0, 0);
        check("post_rst_no_xfer", xfer_n - base, 0);

        // recovery drain after abandoned run
        plan_drain(2, 1'b1, 0, base);
        d0 = done_n;
        pulse_start(2, 1'b1);
        wait_done(d0, 500, 1'b1);
        verify(base, 8);
        tick();

        // protocol invariants over the whole run
        check("rd_en_onehot_viol", onehot_v, 0);
        check("rd_in_send_viol", rdsend_v, 0);
        check("rd_when_empty_viol", rdempty_v, 0);
        check("hold_stable_viol", hold_v, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
